tile_draw_sequencer: RTL and testbench

- Initiator side of the number-drawer interface: walks the 4x4 board and, for each tile, drives a digit drawer's origin, digit select, enable and reset.
- Holds the drawer enable for exactly one full glyph pass, then moves to the next tile.
- Sits between the game-state datapath (board contents, start request) and the numberN drawers / VGA plot path.
- Skips blank tiles and reports completion with a one-cycle pulse.

---
 rtl/tile_draw_sequencer_pkg.sv | 31 +++
 rtl/tile_draw_sequencer_coord_lut.sv | 18 +
 rtl/tile_draw_sequencer.sv | 142 ++++++++++++++
 tb/tb_tile_draw_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_draw_sequencer_pkg.sv
// Shared types and constants for the 4x4 board tile draw sequencer.
package tile_draw_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_DRAW  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int GRID_DIM  = 4;
    localparam int TILE_BITS = 4;
    localparam int NUM_TILES = GRID_DIM * GRID_DIM;
    localparam int BOARD_W   = NUM_TILES * TILE_BITS;
    localparam int X_W       = 8;
    localparam int Y_W       = 7;

    localparam logic [TILE_BITS-1:0] BLANK_TILE = 4'd0;
    localparam logic [3:0]           LAST_INDEX = 4'd15;

    // Nibble for tile idx; tile i occupies bits [4i+3:4i].
    function automatic logic [TILE_BITS-1:0] tile_nibble(
        input logic [BOARD_W-1:0] board,
        input logic [3:0]         idx
    );
        return board[{idx, 2'b00} +: TILE_BITS];
    endfunction

endpackage

// File: rtl/tile_draw_sequencer_coord_lut.sv
// Tile index to drawer origin: column from index[1:0], row from index[3:2].
module tile_coord_lut
    import tile_draw_sequencer_pkg::*;
#(
    parameter int ORIGIN_X   = 20,
    parameter int ORIGIN_Y   = 0,
    parameter int TILE_PITCH = 30
)(
    input  logic [3:0]     index,
    output logic [X_W-1:0] tile_x,
    output logic [Y_W-1:0] tile_y
);

    // Evaluated at the screen widths, so any overflow truncates like the drawer inputs do.
    assign tile_x = X_W'(ORIGIN_X) + X_W'(TILE_PITCH) * {{(X_W-2){1'b0}}, index[1:0]};
    assign tile_y = Y_W'(ORIGIN_Y) + Y_W'(TILE_PITCH) * {{(Y_W-2){1'b0}}, index[3:2]};

endmodule

// File: rtl/tile_draw_sequencer.sv
// Walks the latched 4x4 board and drives one digit drawer pass per non-blank tile.
module tile_draw_sequencer
    import tile_draw_sequencer_pkg::*;
#(
    parameter int DRAW_CYCLES = 111,
    parameter int ORIGIN_X    = 20,
    parameter int ORIGIN_Y    = 0,
    parameter int TILE_PITCH  = 30
)(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [BOARD_W-1:0]   board_state,
    output logic [X_W-1:0]       tile_x,
    output logic [Y_W-1:0]       tile_y,
    output logic [TILE_BITS-1:0] digit,
    output logic                 drawer_enable,
    output logic                 drawer_resetn,
    output logic                 plot,
    output logic                 busy,
    output logic                 done
);

    localparam int              CNT_W    = $clog2(DRAW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAW_CYCLES - 1);

    state_t               state_r, state_next_s;
    logic [3:0]           index_r, index_next_s;
    logic [BOARD_W-1:0]   board_r, board_next_s;
    logic [CNT_W-1:0]     cnt_r, cnt_next_s;
    logic [X_W-1:0]       lut_x_s, x_next_s;
    logic [Y_W-1:0]       lut_y_s, y_next_s;
    logic [TILE_BITS-1:0] digit_next_s;

    tile_coord_lut #(
        .ORIGIN_X   (ORIGIN_X),
        .ORIGIN_Y   (ORIGIN_Y),
        .TILE_PITCH (TILE_PITCH)
    ) u_coord (
        .index  (index_next_s),
        .tile_x (lut_x_s),
        .tile_y (lut_y_s)
    );

    // Next-state, tile index, board latch and glyph cycle counter.
    always_comb begin
        state_next_s = state_r;
        index_next_s = index_r;
        board_next_s = board_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_LOAD;
                    index_next_s = 4'd0;
                    board_next_s = board_state;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // digit already holds this tile's nibble, registered on entry to LOAD.
                if (digit == BLANK_TILE) begin
                    state_next_s = ST_NEXT;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_next_s = ST_DRAW;
                cnt_next_s   = {CNT_W{1'b0}};
            end
            ST_DRAW: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_NEXT;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            ST_NEXT: begin
                if (index_r == LAST_INDEX) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_LOAD;
                    index_next_s = index_r + 4'd1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Drawer origin and digit change only when entering LOAD and are held for the whole tile.
    always_comb begin
        x_next_s     = tile_x;
        y_next_s     = tile_y;
        digit_next_s = digit;
        if (state_next_s == ST_LOAD) begin
            x_next_s     = lut_x_s;
            y_next_s     = lut_y_s;
            digit_next_s = tile_nibble(board_next_s, index_next_s);
        end else begin
            digit_next_s = digit;
        end
    end

    // State, datapath and output registers; outputs are decoded from the state being entered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            index_r       <= 4'd0;
            board_r       <= {BOARD_W{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            tile_x        <= {X_W{1'b0}};
            tile_y        <= {Y_W{1'b0}};
            digit         <= {TILE_BITS{1'b0}};
            drawer_enable <= 1'b0;
            drawer_resetn <= 1'b1;
            plot          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            index_r       <= index_next_s;
            board_r       <= board_next_s;
            cnt_r         <= cnt_next_s;
            tile_x        <= x_next_s;
            tile_y        <= y_next_s;
            digit         <= digit_next_s;
            drawer_enable <= (state_next_s == ST_DRAW);
            drawer_resetn <= (state_next_s != ST_CLEAR);
            plot          <= (state_next_s == ST_DRAW);
            busy          <= (state_next_s != ST_IDLE);
            done          <= (state_next_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_tile_draw_sequencer.sv
// Scoreboard bench: stimulus queues expected draws/done pulses, a negedge monitor checks them.
module tb_tile_draw_sequencer;

    bit          clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [63:0] board_state;
    logic [7:0]  tile_x;
    logic [6:0]  tile_y;
    logic [3:0]  digit;
    logic        drawer_enable, drawer_resetn, plot, busy, done;

    typedef struct {
        bit is_done;
        int x, y, digit, len;
        int cyc, plots;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc     = 0;

    tile_draw_sequencer dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .board_state   (board_state),
        .tile_x        (tile_x),
        .tile_y        (tile_y),
        .digit         (digit),
        .drawer_enable (drawer_enable),
        .drawer_resetn (drawer_resetn),
        .plot          (plot),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected draws come from the tile layout; done cycle and plot total are hand values.
    task automatic push_expect(input logic [63:0] b, input int acc_c, input int n_hand, input int plots_hand);
        exp_t e;
        int   nib;
        for (int i = 0; i < 16; i++) begin
            nib = int'(b[4*i +: 4]);
            if (nib != 0) begin
                e.is_done = 1'b0;
                e.x       = 20 + 30 * (i % 4);
                e.y       = 30 * (i / 4);
                e.digit   = nib;
                e.len     = 111;
                e.cyc     = 0;
                e.plots   = 0;
                sb_q.push_back(e);
            end
        end
        e.is_done = 1'b1;
        e.x = 0; e.y = 0; e.digit = 0; e.len = 0;
        e.cyc   = acc_c + n_hand - 1;
        e.plots = plots_hand;
        sb_q.push_back(e);
    endtask

    // Returns at the negedge of the first LOAD cycle (relative cycle 1, cyc == acc).
    task automatic start_board(input logic [63:0] b, input int n_hand, input int plots_hand, input bit hold);
        @(negedge clk);
        board_state = b;
        start       = 1'b1;
        acc         = cyc + 1;
        push_expect(b, acc, n_hand, plots_hand);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int left;
        left = budget;
        while (sb_q.size() != 0 && left > 0) begin
            @(negedge clk);
            left--;
        end
        check(name, sb_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tile_x"}, int'(tile_x), 0);
        check({tag, "_tile_y"}, int'(tile_y), 0);
        check({tag, "_digit"}, int'(digit), 0);
        check({tag, "_enable"}, int'(drawer_enable), 0);
        check({tag, "_drawer_resetn"}, int'(drawer_resetn), 1);
        check({tag, "_plot"}, int'(plot), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    // Monitor state: current plot run, clear pulse length, plots since last done.
    bit   in_run = 1'b0;
    bit   stable_m;
    bit   busy_chk = 1'b0;
    int   run_len, run_x, run_y, run_d, run_clr;
    int   clr_cnt = 0;
    int   plot_total = 0;
    exp_t e_m;

    // Pops the scoreboard whenever a plot run ends or a done pulse appears.
    always @(negedge clk) begin
        if (!resetn) begin
            in_run     = 1'b0;
            busy_chk   = 1'b0;
            clr_cnt    = 0;
            plot_total = 0;
        end else begin
            if (busy_chk) begin
                check("busy_after_done", int'(busy), 0);
                busy_chk = 1'b0;
            end
            if (!drawer_resetn) clr_cnt++;
            if (plot && !in_run) begin
                in_run   = 1'b1;
                run_len  = 0;
                run_x    = int'(tile_x);
                run_y    = int'(tile_y);
                run_d    = int'(digit);
                run_clr  = clr_cnt;
                stable_m = 1'b1;
            end
            if (plot) begin
                run_len++;
                plot_total++;
                if (int'(tile_x) != run_x || int'(tile_y) != run_y || int'(digit) != run_d || !drawer_enable)
                    stable_m = 1'b0;
            end
            if (!plot && in_run) begin
                in_run = 1'b0;
                check("draw_expected", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e_m = sb_q.pop_front();
                    check("draw_kind", int'(e_m.is_done), 0);
                    check("draw_x", run_x, e_m.x);
                    check("draw_y", run_y, e_m.y);
                    check("draw_digit", run_d, e_m.digit);
                    check("draw_len", run_len, e_m.len);
                    check("draw_clear_len", run_clr, 1);
                    check("draw_stable", int'(stable_m), 1);
                end
                clr_cnt = 0;
            end
            if (done) begin
                check("done_expected", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e_m = sb_q.pop_front();
                    check("done_kind", int'(e_m.is_done), 1);
                    check("done_cycle", cyc, e_m.cyc);
                    check("done_plot_total", plot_total, e_m.plots);
                end
                check("busy_at_done", int'(busy), 1);
                busy_chk   = 1'b1;
                plot_total = 0;
            end
        end
    end

    initial begin
        int plots_seen, busy_seen, acc1;
        resetn      = 1'b0;
        start       = 1'b0;
        board_state = 64'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        resetn = 1'b1;

        // Idle with start low: nothing may plot or go busy.
        plots_seen = 0;
        busy_seen  = 0;
        repeat (50) begin
            @(negedge clk);
            if (plot) plots_seen++;
            if (busy) busy_seen++;
        end
        check("idle_plot_cycles", plots_seen, 0);
        check("idle_busy_cycles", busy_seen, 0);
        check_reset_outputs("idle");

        // Single tile 0 = 6: 114 + 15*2 + 1 = 145 cycles to done.
        start_board(64'h0000_0000_0000_0006, 145, 111, 1'b0);
        check("load_tile_x", int'(tile_x), 20);
        check("load_tile_y", int'(tile_y), 0);
        check("load_digit", int'(digit), 6);
        check("load_busy", int'(busy), 1);
        check("load_drawer_resetn", int'(drawer_resetn), 1);
        @(negedge clk);
        check("clear_drawer_resetn", int'(drawer_resetn), 0);
        check("clear_enable", int'(drawer_enable), 0);
        drain("drain_single", 400);

        // Digits 1..15, tile 15 blank: 15*114 + 2 + 1 = 1713, 15*111 = 1665 plots.
        start_board(64'h0FED_CBA9_8765_4321, 1713, 1665, 1'b0);
        drain("drain_full", 2500);

        // All blank, start held through DONE: re-accepted one IDLE cycle after DONE.
        start_board(64'd0, 33, 0, 1'b1);
        acc1 = acc;
        push_expect(64'd0, acc1 + 34, 33, 0);
        while (cyc != acc1 + 34) @(negedge clk);
        check("rearm_busy", int'(busy), 1);
        start = 1'b0;
        drain("drain_blank", 200);

        // Board change and second start during DRAW of tile 0 must be ignored.
        start_board(64'h0000_0000_0000_0036, 257, 222, 1'b0);
        while (cyc != acc + 39) @(negedge clk);
        board_state = 64'hFFFF_FFFF_FFFF_FFFF;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("drain_middraw_start", 600);

        // Reset asserted at DRAW cycle 50 (relative cycle 53).
        start_board(64'h0000_0000_0000_0006, 145, 111, 1'b0);
        while (cyc != acc + 52) @(negedge clk);
        check("pre_reset_plot", int'(plot), 1);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("async_reset");
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        #2 resetn = 1'b1;
        plots_seen = 0;
        busy_seen  = 0;
        repeat (20) begin
            @(negedge clk);
            if (plot) plots_seen++;
            if (busy) busy_seen++;
        end
        check("post_reset_plot_cycles", plots_seen, 0);
        check("post_reset_busy_cycles", busy_seen, 0);

        start_board(64'd0, 33, 0, 1'b0);
        drain("drain_after_reset", 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
